// File: rtl/llc_cmd_issuer_pkg.sv
// Shared types and op-code constants for the LLC command issuer.
package llc_cmd_issuer_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DUMP} issuerState;

   localparam int OP_IDLE  = 15;
   localparam int OP_CLEAR = 8;
   localparam int OP_PRINT = 9;
   localparam int NUM_OPS  = 10;

   // Ops 0-6 are LLC accesses/snoops; 8 clears the LLC, 9 prints it.
   function automatic logic isLegalOp(input logic [3:0] op);
      return (op <= 4'd6) || (op == 4'(OP_CLEAR)) || (op == 4'(OP_PRINT));
   endfunction

endpackage

// File: rtl/llc_cmd_issuer_fifo.sv
// Synchronous FIFO of {op, addr} commands; level is the difference of 1-bit-wider pointers.
module llc_cmd_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 36
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q[AW-1:0]];
   assign level = wr_ptr_q - rd_ptr_q;
   assign full  = (level == (AW+1)'(DEPTH));
   assign empty = (level == '0);

endmodule

// File: rtl/llc_cmd_issuer.sv
// Buffers trace commands and issues them to the LLC, running print (op 9) via a dump handshake.
// Optional per-op completion counters are built when LLC_ISSUE_STATS_EN is defined.
module llc_cmd_issuer
   import llc_cmd_issuer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [3:0]                    in_op,
   input  logic [31:0]                   in_addr,
   output logic                          llc_valid,
   output logic [31:0]                   llc_op,
   output logic [31:0]                   llc_addr,
   output logic                          dump_req,
   input  logic                          dump_done,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]              drop_cnt
`ifdef LLC_ISSUE_STATS_EN
   ,
   output logic [CNT_W-1:0]              op_cnt [NUM_OPS]
`endif
);

   logic        fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
   logic [35:0] fifo_rdata;
   logic [3:0]  head_op;
   logic [31:0] head_addr;

   issuerState        state_q, state_d;
   logic              llc_valid_q, llc_valid_d;
   logic [31:0]       llc_op_q, llc_op_d;
   logic [31:0]       llc_addr_q, llc_addr_d;
   logic              dump_req_q, dump_req_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   assign {head_op, head_addr} = fifo_rdata;

   // Illegal ops still complete the handshake so the trace reader never stalls on them.
   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready && isLegalOp(in_op);
   assign drop      = in_valid && in_ready && !isLegalOp(in_op);

   llc_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (36)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({in_op, in_addr}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      state_d     = state_q;
      llc_valid_d = 1'b0;
      llc_op_d    = 32'(OP_IDLE);
      llc_addr_d  = '0;
      dump_req_d  = 1'b0;
      fifo_pop    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (head_op == 4'(OP_PRINT)) begin
                  state_d    = S_DUMP;
                  dump_req_d = 1'b1;
               end else begin
                  state_d     = S_ISSUE;
                  llc_valid_d = 1'b1;
                  llc_op_d    = {28'd0, head_op};
                  llc_addr_d  = head_addr;
               end
            end
         end
         S_ISSUE: state_d = S_IDLE;
         S_DUMP: begin
            if (dump_done) state_d    = S_IDLE;
            else           dump_req_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         llc_valid_q <= 1'b0;
         llc_op_q    <= 32'(OP_IDLE);
         llc_addr_q  <= '0;
         dump_req_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         llc_valid_q <= llc_valid_d;
         llc_op_q    <= llc_op_d;
         llc_addr_q  <= llc_addr_d;
         dump_req_q  <= dump_req_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign llc_valid = llc_valid_q;
   assign llc_op    = llc_op_q;
   assign llc_addr  = llc_addr_q;
   assign dump_req  = dump_req_q;
   assign drop_cnt  = drop_cnt_q;
   assign busy      = !fifo_empty || (state_q != S_IDLE);

`ifdef LLC_ISSUE_STATS_EN
   logic [CNT_W-1:0] op_cnt_q [NUM_OPS];
   logic [CNT_W-1:0] op_cnt_d [NUM_OPS];
   logic             cnt_en;
   logic [3:0]       cnt_idx;

   // A command counts when it completes: its ISSUE cycle, or the dump acknowledge for a print.
   always_comb begin
      cnt_en  = 1'b0;
      cnt_idx = llc_op_q[3:0];
      if (state_q == S_ISSUE) begin
         cnt_en = 1'b1;
      end else if ((state_q == S_DUMP) && dump_done) begin
         cnt_en  = 1'b1;
         cnt_idx = 4'(OP_PRINT);
      end
      op_cnt_d = op_cnt_q;
      if (cnt_en && (cnt_idx < 4'(NUM_OPS)) && (op_cnt_q[cnt_idx] != '1)) begin
         op_cnt_d[cnt_idx] = op_cnt_q[cnt_idx] + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_OPS; k++) op_cnt_q[k] <= '0;
      end else begin
         op_cnt_q <= op_cnt_d;
      end
   end

   assign op_cnt = op_cnt_q;
`endif

endmodule

// File: tb/tb_llc_cmd_issuer.sv
// Directed bench for llc_cmd_issuer; inputs change and outputs are sampled on the falling edge.
module tb_llc_cmd_issuer;
   import llc_cmd_issuer_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_addr;
   logic        llc_valid;
   logic [31:0] llc_op;
   logic [31:0] llc_addr;
   logic        dump_req;
   logic        dump_done;
   logic        busy;
   logic [3:0]  fifo_level;
   logic [CW-1:0] drop_cnt;
`ifdef LLC_ISSUE_STATS_EN
   logic [CW-1:0] op_cnt [10];
`endif

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int overlap = 0;
   logic [31:0] obs_op[$];
   logic [31:0] obs_addr[$];
   int          obs_cyc[$];

   llc_cmd_issuer #(
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_addr    (in_addr),
      .llc_valid  (llc_valid),
      .llc_op     (llc_op),
      .llc_addr   (llc_addr),
      .dump_req   (dump_req),
      .dump_done  (dump_done),
      .busy       (busy),
      .fifo_level (fifo_level),
      .drop_cnt   (drop_cnt)
`ifdef LLC_ISSUE_STATS_EN
      ,
      .op_cnt     (op_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every command the LLC would act on.
   always @(negedge clk) begin
      if (!reset) begin
         if (llc_valid) begin
            obs_op.push_back(llc_op);
            obs_addr.push_back(llc_addr);
            obs_cyc.push_back(cyc);
         end
         if (llc_valid && dump_req) overlap++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_obs();
      obs_op.delete();
      obs_addr.delete();
      obs_cyc.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      dump_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      clear_obs();
   endtask

   task automatic push(input logic [3:0] op, input logic [31:0] a);
      in_valid = 1'b1;
      in_op = op;
      in_addr = a;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_dump(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (dump_req) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic pulse_done();
      dump_done = 1'b1;
      @(negedge clk);
      dump_done = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++;
      if ({in_ready, llc_valid, dump_req, busy} !== 4'b1000) begin
         fails++;
         $display("FAIL reset_flags: got rdy/val/dreq/busy=%b required 1000",
                  {in_ready, llc_valid, dump_req, busy});
      end
      tests++;
      if (llc_op !== 32'd15 || llc_addr !== 32'd0) begin
         fails++;
         $display("FAIL reset_llc: got op=%0h addr=%0h required op=f addr=0", llc_op, llc_addr);
      end
      tests++;
      if (fifo_level !== 4'd0 || drop_cnt !== '0) begin
         fails++;
         $display("FAIL reset_cnt: got level=%0d drop=%0d required 0 0", fifo_level, drop_cnt);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || llc_valid !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_idle: got rdy=%b busy=%b val=%b required 1 0 0",
                  in_ready, busy, llc_valid);
      end
      clear_obs();
   endtask

   task automatic test_single_read();
      int cap;
      push(4'd0, 32'h0000_1040);
      cap = cyc;
      tests++;
      if (llc_valid !== 1'b0 || fifo_level !== 4'd1) begin
         fails++;
         $display("FAIL single_no_bypass: got val=%b level=%0d required 0 1", llc_valid, fifo_level);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (obs_op.size() != 1) begin
         fails++;
         $display("FAIL single_count: got %0d commands required 1", obs_op.size());
      end else begin
         tests++;
         if (obs_op[0] !== 32'd0 || obs_addr[0] !== 32'h0000_1040 || obs_cyc[0] != cap + 1) begin
            fails++;
            $display("FAIL single_cmd: got op=%0h addr=%0h edge+%0d required 0 1040 edge+1",
                     obs_op[0], obs_addr[0], obs_cyc[0] - cap);
         end
      end
      clear_obs();
   endtask

   task automatic test_illegal();
      push(4'd7, 32'h70);
      push(4'd12, 32'hC0);
      tests++;
      if (drop_cnt !== 4'd2 || fifo_level !== 4'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL illegal_drop: got drop=%0d level=%0d busy=%b required 2 0 0",
                  drop_cnt, fifo_level, busy);
      end
      repeat (15) push(4'd10 + 4'(cyc % 6), 32'h0);
      tests++;
      if (drop_cnt !== 4'd15 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL drop_saturate: got drop=%0d rdy=%b required 15 1", drop_cnt, in_ready);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (obs_op.size() != 0) begin
         fails++;
         $display("FAIL illegal_issued: got %0d commands required 0", obs_op.size());
      end
   endtask

   task automatic test_back_pressure();
      int bad;
      int accepted;
      do_reset();
      push(4'd9, 32'h0);
      accepted = 0;
      for (int i = 0; i < 8; i++) begin
         if (in_ready) accepted++;
         push((i == 7) ? 4'd8 : 4'(i), 32'h2000 + 32'(i * 16));
      end
      tests++;
      if (accepted != 8 || in_ready !== 1'b0 || fifo_level !== 4'd8 || dump_req !== 1'b1) begin
         fails++;
         $display("FAIL bp_full: got acc=%0d rdy=%b level=%0d dreq=%b required 8 0 8 1",
                  accepted, in_ready, fifo_level, dump_req);
      end
      push(4'd3, 32'hDEAD);
      tests++;
      if (fifo_level !== 4'd8 || llc_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_hold: got level=%0d val=%b required 8 0", fifo_level, llc_valid);
      end
      pulse_done();
      tests++;
      if (dump_req !== 1'b0 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_ack: got dreq=%b rdy=%b required 0 0", dump_req, in_ready);
      end
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || fifo_level !== 4'd7) begin
         fails++;
         $display("FAIL bp_release: got rdy=%b level=%0d required 1 7", in_ready, fifo_level);
      end
      for (int i = 0; i < 30 && obs_op.size() < 8; i++) @(negedge clk);
      tests++;
      if (obs_op.size() != 8) begin
         fails++;
         $display("FAIL bp_drain_count: got %0d commands required 8", obs_op.size());
      end else begin
         bad = 0;
         for (int i = 0; i < 8; i++) begin
            if (obs_op[i] !== ((i == 7) ? 32'd8 : 32'(i)) || obs_addr[i] !== 32'h2000 + 32'(i * 16))
               bad++;
         end
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL bp_drain_order: got %0d out-of-order commands required 0", bad);
         end
         tests++;
         if (obs_cyc[7] - obs_cyc[0] != 14) begin
            fails++;
            $display("FAIL bp_throughput: got span %0d cycles required 14", obs_cyc[7] - obs_cyc[0]);
         end
      end
      clear_obs();
   endtask

   task automatic test_dump_order();
      bit ok;
      overlap = 0;
      push(4'd1, 32'hA);
      push(4'd9, 32'h0);
      push(4'd0, 32'hB);
      wait_dump(ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL dump_timeout: got dump_req=%b required 1", dump_req);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (obs_op.size() != 1 || dump_req !== 1'b1 || llc_valid !== 1'b0) begin
         fails++;
         $display("FAIL dump_stall: got n=%0d dreq=%b val=%b required 1 1 0",
                  obs_op.size(), dump_req, llc_valid);
      end else begin
         tests++;
         if (obs_op[0] !== 32'd1 || obs_addr[0] !== 32'hA) begin
            fails++;
            $display("FAIL dump_before: got op=%0h addr=%0h required 1 a", obs_op[0], obs_addr[0]);
         end
      end
      pulse_done();
      repeat (4) @(negedge clk);
      tests++;
      if (obs_op.size() != 2 || overlap != 0) begin
         fails++;
         $display("FAIL dump_after_count: got n=%0d overlap=%0d required 2 0", obs_op.size(), overlap);
      end else begin
         tests++;
         if (obs_op[1] !== 32'd0 || obs_addr[1] !== 32'hB) begin
            fails++;
            $display("FAIL dump_after: got op=%0h addr=%0h required 0 b", obs_op[1], obs_addr[1]);
         end
      end
      clear_obs();
   endtask

   task automatic test_dump_done_edges();
      bit ok;
      pulse_done();
      push(4'd9, 32'h0);
      wait_dump(ok);
      repeat (2) @(negedge clk);
      tests++;
      if (!ok || dump_req !== 1'b1) begin
         fails++;
         $display("FAIL stray_done: got seen=%b dreq=%b required 1 1", ok, dump_req);
      end
      pulse_done();
      push(4'd9, 32'h0);
      wait_dump(ok);
      pulse_done();
      tests++;
      if (!ok || dump_req !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL immediate_done: got seen=%b dreq=%b busy=%b required 1 0 0",
                  ok, dump_req, busy);
      end
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < 6; i++) push(4'(i), 32'h300 + 32'(i));
      tests++;
      if (llc_valid !== 1'b1 || llc_op !== 32'd2 || fifo_level !== 4'd3) begin
         fails++;
         $display("FAIL midflight_pre: got val=%b op=%0h level=%0d required 1 2 3",
                  llc_valid, llc_op, fifo_level);
      end
      #1 reset = 1'b1;
      #1;
      tests++;
      if (llc_valid !== 1'b0 || llc_op !== 32'd15 || fifo_level !== 4'd0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL midflight_async: got val=%b op=%0h level=%0d rdy=%b required 0 f 0 1",
                  llc_valid, llc_op, fifo_level, in_ready);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      clear_obs();
      repeat (6) @(negedge clk);
      tests++;
      if (obs_op.size() != 0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL midflight_replay: got n=%0d busy=%b required 0 0", obs_op.size(), busy);
      end
   endtask

`ifdef LLC_ISSUE_STATS_EN
   task automatic test_stats();
      bit ok;
      int bad;
      do_reset();
      push(4'd0, 32'h1);
      push(4'd0, 32'h2);
      push(4'd0, 32'h3);
      push(4'd8, 32'h0);
      push(4'd9, 32'h0);
      wait_dump(ok);
      pulse_done();
      repeat (3) @(negedge clk);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (op_cnt[k] !== ((k == 0) ? 4'd3 : (k == 8 || k == 9) ? 4'd1 : 4'd0)) bad++;
      end
      tests++;
      if (!ok || bad != 0) begin
         fails++;
         $display("FAIL stats: got dump=%b wrong=%0d c0=%0d c8=%0d c9=%0d required 1 0 3 1 1",
                  ok, bad, op_cnt[0], op_cnt[8], op_cnt[9]);
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_op = 4'd0;
      in_addr = 32'd0;
      dump_done = 1'b0;
      test_reset();
      test_single_read();
      test_illegal();
      test_back_pressure();
      test_dump_order();
      test_dump_done_edges();
      test_reset_midflight();
`ifdef LLC_ISSUE_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
